// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  // Bit positions inside the 32-bit status/data word
  localparam int unsigned VALID   = 31;
  localparam int unsigned OVF     = 30;
  localparam int unsigned PERR    = 29;
  localparam int unsigned FERR    = 28;
  localparam int unsigned CNT_LSB = 16;

  // start + 8 data + parity + stop
  localparam int unsigned FRAME_BITS = 11;

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO is dropped unless a pop frees a slot that cycle.
module ps2_byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       empty,
  output logic [7:0] count,
  output logic       drop
);
  import ps2_pkg::*;

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign head    = mem[rd_ptr];
  assign count   = 8'(cnt);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host receiver: pin conditioning, frame FSM with timeout,
// sticky error flags and a scancode FIFO exposed as one status/data word.
module ps2_scan_receiver #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FILT       = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2clk,
  input  logic        ps2data,
  input  logic        pop,
  input  logic        clr,
  output logic [31:0] out,
  output logic        irq
);
  import ps2_pkg::*;

  localparam int unsigned FW        = $clog2(FILT + 1);
  localparam int unsigned TW        = $clog2(TIMEOUT + 1);
  localparam int unsigned DATA_BITS = FRAME_BITS - 3;

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_filt, dat_filt;
  logic [FW-1:0] clk_fcnt, dat_fcnt;
  logic          fall;

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_q;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          push, perr_evt, ferr_evt;

  logic          ovf_q, perr_q, ferr_q;
  logic [7:0]    head, count;
  logic          empty, drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[0], ps2clk};
      dat_sync <= {dat_sync[0], ps2data};
    end
  end

  // Level follows the synchronised pin only after FILT consecutive differing samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_filt <= 1'b1;
      clk_fcnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        clk_fcnt <= '0;
      end else if (clk_fcnt == FW'(FILT - 1)) begin
        clk_filt <= clk_sync[1];
        clk_fcnt <= '0;
        fall     <= !clk_sync[1];
      end else begin
        clk_fcnt <= clk_fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dat_filt <= 1'b1;
      dat_fcnt <= '0;
    end else if (dat_sync[1] == dat_filt) begin
      dat_fcnt <= '0;
    end else if (dat_fcnt == FW'(FILT - 1)) begin
      dat_filt <= dat_sync[1];
      dat_fcnt <= '0;
    end else begin
      dat_fcnt <= dat_fcnt + 1'b1;
    end
  end

  assign timeout = (state_q != IDLE) && !fall && (tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    perr_evt = 1'b0;
    ferr_evt = 1'b0;
    if (timeout) begin
      state_d  = IDLE;
      ferr_evt = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE:   if (!dat_filt) state_d = DATA;
        DATA:   if (bit_cnt == 3'(DATA_BITS - 1)) state_d = PARITY;
        PARITY: state_d = STOP;
        STOP: begin
          state_d = IDLE;
          if (!dat_filt)                         ferr_evt = 1'b1;
          else if (!odd_parity_ok(shreg, par_q)) perr_evt = 1'b1;
          else                                   push     = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
      tcnt    <= '0;
    end else begin
      state_q <= state_d;
      if (fall || timeout)      tcnt <= '0;
      else if (state_q != IDLE) tcnt <= tcnt + 1'b1;
      if (fall && !timeout) begin
        case (state_q)
          IDLE:   bit_cnt <= '0;
          DATA: begin
            shreg   <= {dat_filt, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: par_q <= dat_filt;
          default: ;
        endcase
      end
    end
  end

  ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (shreg),
    .head  (head),
    .empty (empty),
    .count (count),
    .drop  (drop)
  );

  // A new error event takes priority over a coincident clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      irq    <= 1'b0;
    end else begin
      irq    <= push && !drop;
      ovf_q  <= drop     ? 1'b1 : (clr ? 1'b0 : ovf_q);
      perr_q <= perr_evt ? 1'b1 : (clr ? 1'b0 : perr_q);
      ferr_q <= ferr_evt ? 1'b1 : (clr ? 1'b0 : ferr_q);
    end
  end

  always_comb begin
    out              = '0;
    out[VALID]       = !empty;
    out[OVF]         = ovf_q;
    out[PERR]        = perr_q;
    out[FERR]        = ferr_q;
    out[CNT_LSB +: 8] = count;
    out[7:0]         = empty ? 8'h00 : head;
  end

endmodule
